mux_4x1_rr_arbiter: RTL
=======================

# mux_4x1_rr_arbiter

Round-robin arbiter that shares one 4:1 multiplexed data path among four requesters and registers the winning word into a single-entry output stage with a valid/ready handshake. It sits in front of the `mux_4x1` data path. It computes the select each cycle, acknowledges the winning requester and holds the output stable under backpressure. Sustained throughput is one word per clock.

## Interface
Parameters:
- `DATA_W`, 4, width of each requester word and of `out_data`.
- `MAX_BURST`, 4, maximum consecutive beats one requester may hold the path; used only when `MUX_ARB_BURST_EN` is defined; must be at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-requester valid; `req[0]` pairs with `a`, `req[1]` with `b`, `req[2]` with `c`, `req[3]` with `d`.
- `a`, `b`, `c`, `d`  in  DATA_W  requester words; each must be stable while its `req` is high.
- `ack`  out  4  combinational one-hot ready; the word is transferred on any edge where `req[i] && ack[i]`.
- `out_valid`  out  1  output stage holds a word.
- `out_data`  out  DATA_W  registered winning word.
- `out_sel`  out  2  registered index of the requester whose word is in `out_data`.
- `grant`  out  4  registered one-hot of `out_sel`; all zeros when `out_valid` is 0.
- `out_ready`  in  1  downstream accepts `out_data` on an edge where `out_valid && out_ready`.

## Operation
- States:
  - IDLE: `out_valid`=0.
  - HOLD: `out_valid`=1.
- `load_en` = IDLE, or (HOLD && `out_ready`).
- Winner selection:
  - Scan `req` starting at pointer `ptr` (2 bits), in the order `ptr`, `ptr+1`, `ptr+2`, `ptr+3` mod 4.
  - The first set bit wins.
  - `ack` = one-hot(winner) when `load_en` && |`req`; otherwise `ack` = 0.
- On an edge with `load_en` && |`req`:
  - `out_data` <= word of the winner.
  - `out_sel` <= winner.
  - `grant` <= one-hot(winner).
  - `out_valid` <= 1, and the state goes to HOLD.
  - `ptr` <= winner+1 mod 4, so 3 wraps to 0.
- On an edge with HOLD && `out_ready` && `req`==0:
  - `out_valid` <= 0 and `grant` <= 0; the state goes to IDLE.
  - `out_data` and `out_sel` keep their last values.
- In HOLD with `out_ready`=0: every output register holds, `ack`=0 and `ptr` holds.
- Arbitration is work-conserving: a lone requester wins every available slot.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `grant`=0.
  - `ptr`=0, burst count=0, state IDLE.
  - `ack`=0 while `rst_n` is low.

## Timing
- Latency is one clock: a word transferred at edge N appears on `out_data` after edge N.
- Combinational paths: `out_ready` -> `ack` and `req` -> `ack`. `ack` has no path from `a`..`d`.
- A requester must not change its word or drop `req` until it sees `ack` high at a clock edge.
- Dropping `req` without a transfer is permitted only while `ack[i]`=0.
- Simultaneous drain and load (HOLD, `out_ready`=1, |`req`): the new word replaces the old one on the same edge and `out_valid` stays 1, with no bubble.
- Asynchronous reset asserted mid-HOLD immediately forces the reset values. The buffered word is discarded.

## Configuration
- `MUX_ARB_BURST_EN` undefined:
  - Pure round-robin; `ptr` advances past the winner after every transfer.
  - With two continuous requesters, the select alternates every beat.
- `MUX_ARB_BURST_EN` defined:
  - Add a burst counter of width clog2(`MAX_BURST`+1), reset value 0.
  - The counter is set to 1 when the winner differs from the previous winner, and incremented when it is the same.
  - While the previous winner still has `req` set and the counter is below `MAX_BURST`, that winner takes priority and `ptr` does not advance.
  - When the counter reaches `MAX_BURST`, `ptr` <= winner+1 and normal round-robin resumes.
  - The counter clears to 0 when the state returns to IDLE.

## Test plan
- Reset and first grant:
  - Hold `rst_n`=0 with `req`=4'hF -> all outputs 0 and `ack`=0.
  - Release with `a`=4'h1 -> `ack`=4'b0001, then `out_data`=4'h1, `out_sel`=0 and `grant`=4'b0001.
- Full rotation:
  - Set `req`=4'hF, `out_ready`=1, `a`/`b`/`c`/`d`=4'h1/4'h2/4'h4/4'h8.
  - Required: `out_sel` = 0,1,2,3,0 on consecutive cycles, `out_data` = 1,2,4,8,1, and `out_valid` never drops.
- Backpressure:
  - In HOLD, set `out_ready`=0 for 3 cycles.
  - Required: `out_data`, `out_sel` and `grant` stay constant and `ack`=0. On the cycle `out_ready` returns to 1, `ack` goes one-hot to the next requester.
- Wrap:
  - Set `req`=4'b1000 alone, then `req`=4'b1001 -> requester 0 wins next (`ptr` wrapped 3->0).
  - Then set `req`=0 with `out_ready`=1 -> `out_valid`=0, `grant`=0, state IDLE.
- Burst mode with `MUX_ARB_BURST_EN` defined and `MAX_BURST`=4:
  - Set `req`=4'b0110 continuously with `out_ready`=1.
  - Required with the macro: `out_sel` = 1,1,1,1,2,2,2,2,1.
  - Required without the macro: 1,2,1,2.
- Reset mid-operation: assert `rst_n`=0 asynchronously between edges while in HOLD -> `out_valid`, `grant` and `ack` drop immediately. After release, requester 0 has first priority.

Source files
------------

// File: rtl/mux_4x1_rr_arbiter.sv
// mux_4x1_rr_arbiter: round-robin arbiter over a 4:1 data mux with a registered valid/ready output stage.
// Optional build macro MUX_ARB_BURST_EN lets one requester keep the path for up to MAX_BURST beats.
module mux_4x1_rr_arbiter #(
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [3:0]        ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic [3:0]        grant,
  input  logic              out_ready
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_next;
  logic [1:0] ptr, ptr_next, rr, win;
  logic load_en, load, drain;
  logic [DATA_W-1:0] win_data;

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be at least 1");
  end

  // First requesting index found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
  always_comb begin
    rr = ptr;
    for (int k = 3; k >= 0; k--) if (req[ptr + 2'(k)]) rr = ptr + 2'(k);
  end

`ifdef MUX_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt, cnt_next;
  logic keep;
  assign keep     = cnt != '0 && cnt < CW'(MAX_BURST) && req[out_sel];
  assign win      = keep ? out_sel : rr;
  assign cnt_next = keep ? cnt + 1'b1 : CW'(1);
  assign ptr_next = cnt_next == CW'(MAX_BURST) ? win + 2'd1 : win;
  // Burst length of the current winner; cleared when the stage empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= cnt_next;
    else if (drain) cnt <= '0;
  end
`else
  assign win      = rr;
  assign ptr_next = win + 2'd1;
`endif

  assign win_data  = win == 2'd0 ? a : win == 2'd1 ? b : win == 2'd2 ? c : d;
  assign out_valid = state == HOLD;

  // Next state and handshake decode; ack is forced low while reset is held
  always_comb begin
    load_en    = state == IDLE || out_ready;
    load       = load_en && |req;
    drain      = state == HOLD && out_ready && !(|req);
    state_next = load ? HOLD : drain ? IDLE : state;
    ack        = (rst_n && load) ? 4'b0001 << win : 4'b0000;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end

  // Output stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      grant    <= '0;
      ptr      <= '0;
    end else if (load) begin
      out_data <= win_data;
      out_sel  <= win;
      grant    <= 4'b0001 << win;
      ptr      <= ptr_next;
    end else if (drain) begin
      grant    <= '0;
    end
  end
endmodule
